// File: rtl/sdram_req_pkg.sv
// Shared types and constants for the SDRAM burst request master.
package sdram_req_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 32;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Small synchronous FIFO with a combinational head and an occupancy count.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sdram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  // Head reads as zero when empty so stale storage never leaks out.
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; only the pointers/count define validity,
  // and leaving it unreset lets it map onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; push+pop in one cycle keeps the count.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_master.sv
// Burst initiator for one SDRAM arbiter client port. Splits a command into
// single-word requests, one outstanding at a time, buffers read data in a
// small FIFO and consumes write data from a valid/ready stream.
// Optional build macro: SDRAM_REQ_PERF_EN adds stall_cnt/req_cnt outputs.
module sdram_req_master
  import sdram_req_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int ADDR_STEP   = 4,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [SDRAM_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [SDRAM_DATA_W-1:0] wdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [SDRAM_DATA_W-1:0] rdata,
  output logic                    done,
  output logic [SDRAM_ADDR_W-1:0] sdram_address,
  output logic                    sdram_rw,
  output logic [SDRAM_DATA_W-1:0] sdram_wdata,
  input  logic [SDRAM_DATA_W-1:0] sdram_rdata,
  input  logic                    sdram_busy,
  output logic                    sdram_in_valid,
  input  logic                    sdram_out_valid,
  output logic                    sdram_prefetch_step
`ifdef SDRAM_REQ_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             req_cnt
`endif
);

  localparam int CNT_W = $clog2(RFIFO_DEPTH) + 1;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_rw;
  logic [SDRAM_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_first;
  logic                    r_wait_first;
  logic                    r_in_valid;
  logic [SDRAM_ADDR_W-1:0] r_sdram_addr;
  logic                    r_sdram_rw;
  logic [SDRAM_DATA_W-1:0] r_sdram_wdata;
  logic                    r_prefetch;

  logic                    w_fire;
  logic                    w_wait_exit;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rd_room;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;

  // Read-data buffer between the arbiter and the accelerator stream.
  sdram_req_fifo #(
    .DEPTH (RFIFO_DEPTH),
    .WIDTH (SDRAM_DATA_W)
  ) u_rfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (sdram_rdata),
    .pop   (w_pop),
    .dout  (rdata),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // A read may only issue when its response is guaranteed a FIFO slot.
  assign w_rd_room   = (w_fifo_count < CNT_W'(RFIFO_DEPTH));
  assign w_pop       = rdata_ready && !w_fifo_empty;
  assign rdata_valid = !w_fifo_empty;

  assign sdram_in_valid      = r_in_valid;
  assign sdram_address       = r_sdram_addr;
  assign sdram_rw            = r_sdram_rw;
  assign sdram_wdata         = r_sdram_wdata;
  assign sdram_prefetch_step = r_prefetch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next_state = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (w_fire) w_next_state = WAIT;
      WAIT:    if (w_wait_exit) w_next_state = (r_remaining == LEN_W'(1)) ? DONE : ISSUE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Per-state outputs and handshake decodes.
  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    w_fire      = 1'b0;
    w_wait_exit = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE:  cmd_ready = 1'b1;
      ISSUE: w_fire = !sdram_busy && (r_rw ? wdata_valid : w_rd_room);
      WAIT: begin
        // Writes ignore the first WAIT cycle while the arbiter raises busy.
        w_wait_exit = r_rw ? (!r_wait_first && !sdram_busy) : sdram_out_valid;
        w_push      = !r_rw && sdram_out_valid;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
    wdata_ready = w_fire && r_rw;
  end

  // Burst bookkeeping and the registered request bus to the arbiter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_first       <= 1'b0;
      r_wait_first  <= 1'b0;
      r_in_valid    <= 1'b0;
      r_sdram_addr  <= '0;
      r_sdram_rw    <= 1'b0;
      r_sdram_wdata <= '0;
      r_prefetch    <= 1'b0;
    end else begin
      r_in_valid   <= w_fire;
      r_wait_first <= w_fire;
      if (r_state == IDLE && cmd_valid) begin
        r_rw        <= cmd_rw;
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len;
        r_first     <= 1'b1;
      end
      if (w_fire) begin
        r_sdram_addr <= r_addr;
        r_sdram_rw   <= r_rw;
        r_prefetch   <= !r_first;
        r_first      <= 1'b0;
        if (r_rw) r_sdram_wdata <= wdata;
      end
      if (w_wait_exit) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_addr      <= r_addr + SDRAM_ADDR_W'(ADDR_STEP);
      end
    end
  end

  // The issue check reserves a slot for every read response.
  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));

`ifdef SDRAM_REQ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_req_cnt;

  assign stall_cnt = r_stall_cnt;
  assign req_cnt   = r_req_cnt;

  // Saturating stall and request counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_req_cnt   <= '0;
    end else begin
      if (r_state == ISSUE && !w_fire && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (r_in_valid && r_req_cnt != '1) r_req_cnt <= r_req_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_req_master.sv
// Directed bench for sdram_req_master with a fixed-latency arbiter responder.
`timescale 1ns/1ps
module tb_sdram_req_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic [23:0] sdram_address;
  logic        sdram_rw;
  logic [31:0] sdram_wdata;
  logic [31:0] sdram_rdata;
  logic        sdram_busy;
  logic        sdram_in_valid;
  logic        sdram_out_valid;
  logic        sdram_prefetch_step;

  int n_checks = 0;
  int n_errors = 0;

  // Observations gathered by the monitor; tests read them via base indices.
  logic [23:0] req_addr[$];
  logic        req_rw[$];
  logic [31:0] req_wdata[$];
  logic        req_pf[$];
  logic [31:0] got[$];
  int          n_done = 0;
  int          n_wready = 0;

  always #5 clk = ~clk;

  sdram_req_master dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_rw              (cmd_rw),
    .cmd_addr            (cmd_addr),
    .cmd_len             (cmd_len),
    .wdata_valid         (wdata_valid),
    .wdata_ready         (wdata_ready),
    .wdata               (wdata),
    .rdata_valid         (rdata_valid),
    .rdata_ready         (rdata_ready),
    .rdata               (rdata),
    .done                (done),
    .sdram_address       (sdram_address),
    .sdram_rw            (sdram_rw),
    .sdram_wdata         (sdram_wdata),
    .sdram_rdata         (sdram_rdata),
    .sdram_busy          (sdram_busy),
    .sdram_in_valid      (sdram_in_valid),
    .sdram_out_valid     (sdram_out_valid),
    .sdram_prefetch_step (sdram_prefetch_step)
  );

  // Monitor: samples mid-cycle, away from the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sdram_in_valid) begin
        req_addr.push_back(sdram_address);
        req_rw.push_back(sdram_rw);
        req_wdata.push_back(sdram_wdata);
        req_pf.push_back(sdram_prefetch_step);
      end
      if (done) n_done++;
      if (wdata_ready) n_wready++;
      if (rdata_valid && rdata_ready) got.push_back(rdata);
    end
  end

  // Responder: busy for 4 cycles after in_valid; reads return {DA, addr}.
  initial begin : responder
    logic [23:0] a;
    logic        w;
    sdram_busy      = 1'b0;
    sdram_out_valid = 1'b0;
    sdram_rdata     = '0;
    forever begin
      @(posedge clk); #1;
      if (sdram_in_valid) begin
        a = sdram_address;
        w = sdram_rw;
        sdram_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sdram_busy = 1'b0;
        if (!w) begin
          sdram_out_valid = 1'b1;
          sdram_rdata     = {8'hDA, a};
          @(posedge clk); #1;
          sdram_out_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [23:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k = 0;
    while (n_done == base && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (n_done == base) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    int k = 0;
    wdata_valid = 1'b1;
    wdata       = d;
    #1;
    while (!wdata_ready && k < 100) begin
      tick();
      k++;
    end
    n_checks++;
    if (!wdata_ready) begin
      n_errors++;
      $display("FAIL wdata_accept: word %h never accepted", d);
    end
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
    n_checks++; if ({sdram_in_valid, sdram_rw, sdram_prefetch_step, done, wdata_ready, rdata_valid} !== 6'b0) begin
      n_errors++; $display("FAIL rst_flags: got %b exp 000000",
        {sdram_in_valid, sdram_rw, sdram_prefetch_step, done, wdata_ready, rdata_valid});
    end
    n_checks++; if (sdram_address !== 24'h0) begin n_errors++; $display("FAIL rst_addr: got %h exp 000000", sdram_address); end
    n_checks++; if ({sdram_wdata, rdata} !== 64'h0) begin n_errors++; $display("FAIL rst_data: got %h exp 0", {sdram_wdata, rdata}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_read_burst();
    int br = req_addr.size();
    int bg = got.size();
    int bd = n_done;
    logic [23:0] ea[3];
    logic [31:0] ed[3];
    logic        ep[3];
    ea = '{24'h000100, 24'h000104, 24'h000108};
    ed = '{32'hDA000100, 32'hDA000104, 32'hDA000108};
    ep = '{1'b0, 1'b1, 1'b1};
    rdata_ready = 1'b1;
    send_cmd(1'b0, 24'h000100, 8'd3);
    wait_done(bd, 200);
    tick(3);
    n_checks++; if (req_addr.size() - br != 3) begin n_errors++; $display("FAIL rd_req_count: got %0d exp 3", req_addr.size() - br); end
    n_checks++; if (got.size() - bg != 3) begin n_errors++; $display("FAIL rd_word_count: got %0d exp 3", got.size() - bg); end
    for (int i = 0; i < 3; i++) begin
      if (req_addr.size() > br + i) begin
        n_checks++; if (req_addr[br+i] !== ea[i]) begin n_errors++; $display("FAIL rd_addr[%0d]: got %h exp %h", i, req_addr[br+i], ea[i]); end
        n_checks++; if (req_pf[br+i] !== ep[i]) begin n_errors++; $display("FAIL rd_prefetch[%0d]: got %b exp %b", i, req_pf[br+i], ep[i]); end
        n_checks++; if (req_rw[br+i] !== 1'b0) begin n_errors++; $display("FAIL rd_rw[%0d]: got %b exp 0", i, req_rw[br+i]); end
      end
      if (got.size() > bg + i) begin
        n_checks++; if (got[bg+i] !== ed[i]) begin n_errors++; $display("FAIL rd_data[%0d]: got %h exp %h", i, got[bg+i], ed[i]); end
      end
    end
    n_checks++; if (n_done - bd != 1) begin n_errors++; $display("FAIL rd_done_count: got %0d exp 1", n_done - bd); end
  endtask

  task automatic test_write_burst();
    int br = req_addr.size();
    int bd = n_done;
    int bw = n_wready;
    wdata_valid = 1'b0;
    send_cmd(1'b1, 24'h000200, 8'd2);
    tick(5);
    n_checks++; if (req_addr.size() != br) begin n_errors++; $display("FAIL wr_no_req_while_invalid: got %0d exp 0", req_addr.size() - br); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL wr_busy_while_invalid: cmd_ready got %b exp 0", cmd_ready); end
    push_word(32'hD0D0_0000);
    push_word(32'hD1D1_1111);
    wdata_valid = 1'b0;
    wait_done(bd, 200);
    tick(2);
    n_checks++; if (req_addr.size() - br != 2) begin n_errors++; $display("FAIL wr_req_count: got %0d exp 2", req_addr.size() - br); end
    if (req_addr.size() >= br + 2) begin
      n_checks++; if ({req_addr[br], req_wdata[br], req_rw[br], req_pf[br]} !== {24'h000200, 32'hD0D0_0000, 1'b1, 1'b0}) begin
        n_errors++; $display("FAIL wr_req0: got %h/%h/%b/%b exp 000200/d0d00000/1/0", req_addr[br], req_wdata[br], req_rw[br], req_pf[br]);
      end
      n_checks++; if ({req_addr[br+1], req_wdata[br+1], req_rw[br+1], req_pf[br+1]} !== {24'h000204, 32'hD1D1_1111, 1'b1, 1'b1}) begin
        n_errors++; $display("FAIL wr_req1: got %h/%h/%b/%b exp 000204/d1d11111/1/1", req_addr[br+1], req_wdata[br+1], req_rw[br+1], req_pf[br+1]);
      end
    end
    n_checks++; if (n_wready - bw != 2) begin n_errors++; $display("FAIL wr_wready_pulses: got %0d exp 2", n_wready - bw); end
    n_checks++; if (n_done - bd != 1) begin n_errors++; $display("FAIL wr_done_count: got %0d exp 1", n_done - bd); end
  endtask

  task automatic test_fifo_stall();
    int br = req_addr.size();
    int bg = got.size();
    int bd = n_done;
    logic [31:0] exp_d;
    rdata_ready = 1'b0;
    send_cmd(1'b0, 24'h001000, 8'd6);
    tick(40);
    n_checks++; if (req_addr.size() - br != 4) begin n_errors++; $display("FAIL stall_req_count: got %0d exp 4", req_addr.size() - br); end
    n_checks++; if ({cmd_ready, rdata_valid} !== 2'b01) begin n_errors++; $display("FAIL stall_state: cmd_ready/rdata_valid got %b exp 01", {cmd_ready, rdata_valid}); end
    n_checks++; if (got.size() != bg) begin n_errors++; $display("FAIL stall_no_pop: got %0d exp 0", got.size() - bg); end
    rdata_ready = 1'b1;
    wait_done(bd, 300);
    tick(4);
    n_checks++; if (req_addr.size() - br != 6) begin n_errors++; $display("FAIL stall_total_reqs: got %0d exp 6", req_addr.size() - br); end
    n_checks++; if (got.size() - bg != 6) begin n_errors++; $display("FAIL stall_words: got %0d exp 6", got.size() - bg); end
    for (int i = 0; i < 6; i++) begin
      exp_d = 32'hDA001000 + 32'(4 * i);
      if (got.size() > bg + i) begin
        n_checks++; if (got[bg+i] !== exp_d) begin n_errors++; $display("FAIL stall_data[%0d]: got %h exp %h", i, got[bg+i], exp_d); end
      end
    end
  endtask

  task automatic test_wrap();
    int br = req_addr.size();
    int bd = n_done;
    send_cmd(1'b1, 24'hFFFFFC, 8'd2);
    push_word(32'hE0E0_E0E0);
    push_word(32'hE1E1_E1E1);
    wdata_valid = 1'b0;
    wait_done(bd, 200);
    tick(2);
    n_checks++; if (req_addr.size() - br != 2) begin n_errors++; $display("FAIL wrap_req_count: got %0d exp 2", req_addr.size() - br); end
    if (req_addr.size() >= br + 2) begin
      n_checks++; if (req_addr[br] !== 24'hFFFFFC) begin n_errors++; $display("FAIL wrap_addr0: got %h exp fffffc", req_addr[br]); end
      n_checks++; if (req_addr[br+1] !== 24'h000000) begin n_errors++; $display("FAIL wrap_addr1: got %h exp 000000", req_addr[br+1]); end
      n_checks++; if (req_wdata[br+1] !== 32'hE1E1_E1E1) begin n_errors++; $display("FAIL wrap_wdata1: got %h exp e1e1e1e1", req_wdata[br+1]); end
    end
  endtask

  task automatic test_len_zero();
    int br = req_addr.size();
    int bd = n_done;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL len0_ready: got %b exp 1", cmd_ready); end
    send_cmd(1'b0, 24'h000050, 8'd0);
    n_checks++; if ({done, cmd_ready} !== 2'b10) begin n_errors++; $display("FAIL len0_done_next: done/cmd_ready got %b exp 10", {done, cmd_ready}); end
    tick();
    n_checks++; if ({done, cmd_ready} !== 2'b01) begin n_errors++; $display("FAIL len0_back_idle: done/cmd_ready got %b exp 01", {done, cmd_ready}); end
    tick(4);
    n_checks++; if (req_addr.size() != br) begin n_errors++; $display("FAIL len0_no_req: got %0d exp 0", req_addr.size() - br); end
    n_checks++; if (n_done - bd != 1) begin n_errors++; $display("FAIL len0_done_count: got %0d exp 1", n_done - bd); end
  endtask

  task automatic test_reset_mid_burst();
    int br = req_addr.size();
    int bg;
    int bd;
    int k = 0;
    rdata_ready = 1'b1;
    send_cmd(1'b0, 24'h000300, 8'd1);
    while (req_addr.size() == br && k < 50) begin
      tick();
      k++;
    end
    tick();
    rst_n = 1'b0;
    #2;
    n_checks++; if ({cmd_ready, sdram_in_valid, done, rdata_valid, wdata_ready} !== 5'b10000) begin
      n_errors++; $display("FAIL midrst_flags: got %b exp 10000", {cmd_ready, sdram_in_valid, done, rdata_valid, wdata_ready});
    end
    n_checks++; if ({sdram_address, sdram_rw, sdram_prefetch_step} !== 26'h0) begin
      n_errors++; $display("FAIL midrst_bus: got %h/%b/%b exp 0", sdram_address, sdram_rw, sdram_prefetch_step);
    end
    bg = got.size();
    tick();
    rst_n = 1'b1;
    tick(8);
    n_checks++; if (rdata_valid !== 1'b0 || got.size() != bg) begin
      n_errors++; $display("FAIL midrst_fifo_empty: rdata_valid %b words %0d exp 0/0", rdata_valid, got.size() - bg);
    end
    br = req_addr.size();
    bd = n_done;
    send_cmd(1'b0, 24'h000400, 8'd1);
    wait_done(bd, 100);
    tick(3);
    n_checks++; if (got.size() - bg != 1) begin n_errors++; $display("FAIL midrst_new_words: got %0d exp 1", got.size() - bg); end
    else begin
      n_checks++; if (got[bg] !== 32'hDA000400) begin n_errors++; $display("FAIL midrst_new_data: got %h exp da000400", got[bg]); end
    end
    n_checks++; if (req_addr.size() - br != 1) begin n_errors++; $display("FAIL midrst_new_reqs: got %0d exp 1", req_addr.size() - br); end
    else begin
      n_checks++; if ({req_addr[br], req_pf[br]} !== {24'h000400, 1'b0}) begin
        n_errors++; $display("FAIL midrst_new_req: got %h/%b exp 000400/0", req_addr[br], req_pf[br]);
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_read_burst();
    test_write_burst();
    test_fifo_stall();
    test_wrap();
    test_len_zero();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_req_master.md
Name: sdram_req_master

Overview:
Burst initiator for one client port of the SDRAM arbiter (the FIR/MM-side controller interface). It takes a command (start address, word count, read/write) and splits it into single-word requests. It drives address/rw/in_valid/prefetch_step, and watches busy and out_valid. Read data is buffered in a small FIFO and handed to the accelerator as a valid/ready stream. Write data comes in as a valid/ready stream.

Parameters:
LEN_W, 8, width of the burst word count; maximum burst is 2^LEN_W-1 words.
ADDR_STEP, 4, byte increment added to the SDRAM address per word.
RFIFO_DEPTH, 4, read-data FIFO depth; must be a power of 2 and at least 2.

Ports:
clk  in  1  single clock for the whole block
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_rw  in  1  1 = write, 0 = read
cmd_addr  in  24  start byte address
cmd_len  in  LEN_W  word count; 0 means no-op
wdata_valid  in  1  write stream valid
wdata_ready  out  1  write stream ready
wdata  in  32  write word
rdata_valid  out  1  read FIFO not empty
rdata_ready  in  1  read stream consume
rdata  out  32  read FIFO head
done  out  1  one-cycle pulse when a burst completes
sdram_address  out  24  to the arbiter's *_address input
sdram_rw  out  1  to *_rw
sdram_wdata  out  32  to data_from_*
sdram_rdata  in  32  from data_to_*
sdram_busy  in  1  from *_busy
sdram_in_valid  out  1  to *_in_valid (one-cycle pulse)
sdram_out_valid  in  1  from *_out_valid
sdram_prefetch_step  out  1  to *_prefetch_step

Behaviour:
- Reset (rst_n low, asynchronous): state is IDLE. All outputs are 0 except cmd_ready=1. The FIFO is emptied and counters are cleared. A reset mid-burst abandons the burst; any later sdram_out_valid is ignored until a new read is issued.
- States:
  - IDLE to ISSUE on cmd_valid with cmd_len not 0. The block latches addr, len and rw, and sets remaining=len.
  - cmd_len=0 is accepted and produces done the next cycle, with no SDRAM traffic.
  - ISSUE: the request fires when sdram_busy==0 and:
    - for a write, wdata_valid==1;
    - for a read, FIFO occupancy < RFIFO_DEPTH.
  - On fire: sdram_in_valid=1 for exactly one cycle, with address, rw and wdata registered. wdata_ready=1 only in the fire cycle, so the write word is consumed at issue. Then go to WAIT.
  - WAIT, read: leave when sdram_out_valid==1. sdram_rdata is pushed into the FIFO that same cycle. This push is guaranteed space because of the issue check.
  - WAIT, write: the first cycle after issue is ignored (busy settles). Leave when sdram_busy==0 on a later cycle.
  - On leaving WAIT: remaining decrements and address += ADDR_STEP, modulo 2^24 (wraps from 0xFFFFFC to 0x000000). If remaining becomes 0, go to DONE; otherwise go to ISSUE.
  - DONE: done=1 for one cycle, then IDLE.
- At most one outstanding request at any time.
- sdram_prefetch_step=1 on every request of a burst after the first (sequential hint). It is 0 on the first request.
- FIFO:
  - rdata and rdata_valid are read combinationally from the head.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - A push when full cannot happen; an assertion flags it.
  - A pop when empty is ignored.
- done is not delayed by undrained FIFO data. The next command may start while the FIFO still holds data; the issue check throttles it.
- If sdram_out_valid arrives outside a read WAIT, it is dropped and does not change state.

Optional Feature:
SDRAM_REQ_PERF_EN.
- Defined: extra outputs stall_cnt[31:0] and req_cnt[31:0].
  - stall_cnt counts cycles in ISSUE where the request did not fire.
  - req_cnt counts in_valid pulses.
  - Both saturate and are cleared by rst_n only.
- Undefined: neither port nor counter exists. Functional behaviour is identical either way.

Decomposition:
- Package sdram_req_pkg holds:
  - constants SDRAM_ADDR_W=24 and SDRAM_DATA_W=32;
  - the state enum {IDLE, ISSUE, WAIT, DONE}.
- One sub-module, sdram_req_fifo: a synchronous FIFO with parameters DEPTH and WIDTH, outputs count/full/empty, and a combinational head.

Test Plan:
- Read burst, addr=0x000100, len=3, responder returning out_valid 4 cycles after each in_valid with data A,B,C. Expect:
  - three in_valid pulses at 0x100, 0x104, 0x108;
  - prefetch_step 0,1,1;
  - rdata A,B,C in order;
  - done once.
- Write burst, len=2, wdata_valid held low for 5 cycles, then D0,D1 presented. Expect:
  - no in_valid while the stream is invalid;
  - then writes of D0 to addr and D1 to addr+4;
  - wdata_ready pulses exactly twice.
- Read len=6 with rdata_ready=0 (RFIFO_DEPTH=4). Expect:
  - exactly 4 requests, then the block stalls in ISSUE;
  - after rdata_ready=1, the remaining 2 issue;
  - 6 words are delivered.
- Wrap: write at addr=0xFFFFFC, len=2. Expect the second request at 0x000000.
- cmd_len=0. Expect cmd accepted, done the next cycle, zero in_valid pulses.
- rst_n dropped during read WAIT with an out_valid arriving afterwards. Expect:
  - outputs at reset values;
  - FIFO stays empty;
  - a new read of len=1 completes normally.
